// File: rtl/ts_chk_pkg.sv
// rtl/ts_chk_pkg.sv - shared types and constants for the multi-PID TS payload checker
package ts_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INT  = 3'd1,
    ST_LEN  = 3'd2,
    ST_SYN  = 3'd3,
    ST_PID  = 3'd4,
    ST_BODY = 3'd5
  } state_e;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         PID_W        = 13;
  localparam int         CC_W         = 4;
  localparam logic [PID_W-1:0] NULL_PID = 13'h1FFF;

endpackage

// File: rtl/ts_cc_tracker.sv
// rtl/ts_cc_tracker.sv - per-PID continuity counter learning and checking
// TS_CHK_DUP_EN: accept one consecutive duplicate CC per channel
module ts_cc_tracker
  import ts_chk_pkg::*;
#(
  parameter int NUM_PID = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     chk,
  input  logic [PID_W-1:0]         pid,
  input  logic                     afc,
  input  logic [CC_W-1:0]          cc,
  input  logic [PID_W*NUM_PID-1:0] pid_cfg,
  output logic                     err_pulse,
  output logic [NUM_PID-1:0]       err_mask
);

  logic [NUM_PID-1:0]           learned_q, learned_d;
  logic [NUM_PID-1:0][CC_W-1:0] last_q, last_d;
  logic [NUM_PID-1:0]           sel;
  logic                         found;
  logic                         active;
  logic [CC_W-1:0]              nxt;
`ifdef TS_CHK_DUP_EN
  logic [NUM_PID-1:0]           dup_q, dup_d;
`endif

  // Lowest configured index wins when several channels carry the same PID.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PID; i++) begin
      if (!found && (pid_cfg[i*PID_W +: PID_W] == pid)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign active = chk && afc && (pid != NULL_PID);

  always_comb begin
    learned_d = learned_q;
    last_d    = last_q;
    err_mask  = '0;
    nxt       = '0;
`ifdef TS_CHK_DUP_EN
    dup_d     = dup_q;
`endif
    for (int i = 0; i < NUM_PID; i++) begin
      if (active && sel[i]) begin
        nxt          = last_q[i] + CC_W'(1);
        last_d[i]    = cc;
        learned_d[i] = 1'b1;
`ifdef TS_CHK_DUP_EN
        dup_d[i] = 1'b0;
        if (learned_q[i] && (cc != nxt)) begin
          if ((cc == last_q[i]) && !dup_q[i]) dup_d[i] = 1'b1;
          else err_mask[i] = 1'b1;
        end
`else
        if (learned_q[i] && (cc != nxt)) err_mask[i] = 1'b1;
`endif
      end
    end
  end

  assign err_pulse = |err_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      learned_q <= '0;
      last_q    <= '0;
`ifdef TS_CHK_DUP_EN
      dup_q     <= '0;
`endif
    end else begin
      learned_q <= learned_d;
      last_q    <= last_d;
`ifdef TS_CHK_DUP_EN
      dup_q     <= dup_d;
`endif
    end
  end

endmodule

// File: rtl/ts_multi_pid_checker.sv
// rtl/ts_multi_pid_checker.sv - passive framing/sync/length/CC checker for the TS payload bus
// TS_CHK_DUP_EN: legal single duplicate CC per channel (handled in ts_cc_tracker)
module ts_multi_pid_checker
  import ts_chk_pkg::*;
#(
  parameter int          NUM_PID   = 4,
  parameter int          PKT_BYTES = 188,
  parameter logic [15:0] HDR_WORD  = 16'h8001,
  parameter logic [15:0] LEN_WORD  = 16'h00bc,
  parameter int          CNT_W     = 16
) (
  input  logic                     payload_clk,
  input  logic                     payload_rst_n,
  input  logic                     payload_in_valid,
  input  logic                     payload_in_start,
  input  logic                     payload_in_end,
  input  logic [15:0]              payload_in_data,
  input  logic [PID_W*NUM_PID-1:0] pid_cfg,
  input  logic                     err_clr,
  output logic                     syn_err,
  output logic                     len_err,
  output logic                     cc_err,
  output logic                     err_flag,
  output logic [CNT_W-1:0]         syn_err_cnt,
  output logic [CNT_W-1:0]         len_err_cnt,
  output logic [CNT_W-1:0]         cc_err_cnt,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic [NUM_PID-1:0]       cc_err_chan
);

  localparam logic [15:0]      PKT_WORDS = 16'(PKT_BYTES / 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [PID_W-1:0]   pid_q, pid_d;
  logic               afc_q, afc_d;
  logic [CC_W-1:0]    cc_q, cc_d;
  logic               chk_q, chk_d;
  logic               frame_err_q, frame_err_d;
  logic               syn_ev, len_ev, pkt_inc;
  logic               cc_pulse;
  logic [NUM_PID-1:0] cc_mask;

  logic               syn_err_q, syn_err_d, len_err_q, len_err_d, cc_err_q, cc_err_d;
  logic [CNT_W-1:0]   syn_cnt_q, syn_cnt_d, len_cnt_q, len_cnt_d, cc_cnt_q, cc_cnt_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [NUM_PID-1:0] chan_q, chan_d;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic ev, input logic clr);
    if (ev) return clr ? CNT_ONE : ((cnt == CNT_MAX) ? cnt : cnt + CNT_ONE);
    return clr ? '0 : cnt;
  endfunction

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    pid_d       = pid_q;
    afc_d       = afc_q;
    cc_d        = cc_q;
    chk_d       = 1'b0;
    frame_err_d = frame_err_q | cc_pulse;
    syn_ev      = 1'b0;
    len_ev      = 1'b0;
    pkt_inc     = 1'b0;
    if (payload_in_valid) begin
      if (payload_in_start) begin
        // A start anywhere but IDLE abandons the frame and is re-parsed as a new header.
        if (state_q != ST_IDLE) len_ev = 1'b1;
        frame_err_d = 1'b0;
        if (payload_in_data == HDR_WORD) begin
          state_d = ST_INT;
        end else begin
          syn_ev  = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_IDLE;
          ST_INT: begin
            if (payload_in_end) begin
              len_ev  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LEN;
            end
          end
          ST_LEN: begin
            if (payload_in_end || (payload_in_data != LEN_WORD)) begin
              len_ev  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_SYN;
            end
          end
          ST_SYN: begin
            if (payload_in_data[15:8] != TS_SYNC_BYTE) begin
              syn_ev      = 1'b1;
              frame_err_d = 1'b1;
            end
            pid_d[12:8] = payload_in_data[4:0];
            word_cnt_d  = 16'd1;
            if (payload_in_end) begin
              len_ev  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PID;
            end
          end
          ST_PID: begin
            pid_d[7:0] = payload_in_data[15:8];
            afc_d      = payload_in_data[4];
            cc_d       = payload_in_data[3:0];
            word_cnt_d = word_cnt_q + 16'd1;
            if (payload_in_end) begin
              len_ev  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              chk_d   = 1'b1;
              state_d = ST_BODY;
            end
          end
          ST_BODY: begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (payload_in_end) begin
              if (word_cnt_d != PKT_WORDS) len_ev = 1'b1;
              else if (!frame_err_d) pkt_inc = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  ts_cc_tracker #(
    .NUM_PID (NUM_PID)
  ) u_cc_tracker (
    .clk       (payload_clk),
    .rst_n     (payload_rst_n),
    .chk       (chk_q),
    .pid       (pid_q),
    .afc       (afc_q),
    .cc        (cc_q),
    .pid_cfg   (pid_cfg),
    .err_pulse (cc_pulse),
    .err_mask  (cc_mask)
  );

  // A new event in the same cycle as err_clr survives the clear.
  always_comb begin
    syn_err_d = syn_ev   | (syn_err_q & ~err_clr);
    len_err_d = len_ev   | (len_err_q & ~err_clr);
    cc_err_d  = cc_pulse | (cc_err_q  & ~err_clr);
    syn_cnt_d = cnt_next(syn_cnt_q, syn_ev,   err_clr);
    len_cnt_d = cnt_next(len_cnt_q, len_ev,   err_clr);
    cc_cnt_d  = cnt_next(cc_cnt_q,  cc_pulse, err_clr);
    chan_d    = cc_mask | (chan_q & ~{NUM_PID{err_clr}});
    pkt_cnt_d = pkt_cnt_q + (pkt_inc ? CNT_ONE : '0);
  end

  always_ff @(posedge payload_clk or negedge payload_rst_n) begin
    if (!payload_rst_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      pid_q       <= '0;
      afc_q       <= 1'b0;
      cc_q        <= '0;
      chk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      syn_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      cc_err_q    <= 1'b0;
      syn_cnt_q   <= '0;
      len_cnt_q   <= '0;
      cc_cnt_q    <= '0;
      pkt_cnt_q   <= '0;
      chan_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      pid_q       <= pid_d;
      afc_q       <= afc_d;
      cc_q        <= cc_d;
      chk_q       <= chk_d;
      frame_err_q <= frame_err_d;
      syn_err_q   <= syn_err_d;
      len_err_q   <= len_err_d;
      cc_err_q    <= cc_err_d;
      syn_cnt_q   <= syn_cnt_d;
      len_cnt_q   <= len_cnt_d;
      cc_cnt_q    <= cc_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      chan_q      <= chan_d;
    end
  end

  assign syn_err     = syn_err_q;
  assign len_err     = len_err_q;
  assign cc_err      = cc_err_q;
  assign err_flag    = syn_err_q | len_err_q | cc_err_q;
  assign syn_err_cnt = syn_cnt_q;
  assign len_err_cnt = len_cnt_q;
  assign cc_err_cnt  = cc_cnt_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign cc_err_chan = chan_q;

endmodule
